pmod_joystick_conditioner: RTL and testbench

//  Conditions raw Atari-style joystick lines from the two Pmod ports (JA, JB) before they reach mainboard.joy1/joy2.
//  Per line: 2-flop synchroniser, tick-based debounce, active-low to active-high inversion.

---
 rtl/pmod_joystick_conditioner_if.sv | 15 +
 rtl/pmod_joystick_conditioner.sv | 113 +++++++++++
 tb/tb_pmod_joystick_conditioner.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pmod_joystick_conditioner_if.sv
// Joystick signal bundle between the Pmod pin side and the mainboard side.
// master = pin/stimulus driver, slave = conditioner.
interface pmod_joystick_conditioner_if;
  logic [4:0] ja_pin;
  logic [4:0] jb_pin;
  logic [1:0] autofire;
  logic [0:4] joy1;
  logic [0:4] joy2;
  logic       joy_changed;

  modport master (output ja_pin, output jb_pin, output autofire,
                  input  joy1,   input  joy2,   input  joy_changed);
  modport slave  (input  ja_pin, input  jb_pin, input  autofire,
                  output joy1,   output joy2,   output joy_changed);
endinterface

// File: rtl/pmod_joystick_conditioner.sv
// Synchronise, debounce, invert and remap two Atari-style Pmod joysticks.
// Optional autofire on the fire line is enabled by `define MEGA99_JOY_AUTOFIRE_EN.
module pmod_joystick_conditioner #(
  parameter int PRESCALE       = 1000,
  parameter int DEBOUNCE_TICKS = 5,
  parameter int AUTOFIRE_TICKS = 40
) (
  input  logic                              clk,
  input  logic                              reset,
  pmod_joystick_conditioner_if.slave        bus
);

  logic [15:0] r_pre;
  logic        w_tick;
  logic [9:0]  w_raw;
  logic [9:0]  r_s1;
  logic [9:0]  r_s2;
  logic [9:0]  r_stable;
  logic [3:0]  r_cnt [10];
  logic [1:0]  w_fire_db;
  logic [1:0]  w_fire;
  logic [0:4]  w_joy1_next;
  logic [0:4]  w_joy2_next;

  assign w_tick = (r_pre == 16'(PRESCALE - 1));
  assign w_raw  = {bus.jb_pin, bus.ja_pin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 16'd1;
    end
  end

  // Any sample matching the stable level clears the count, so bounce restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= '1;
      r_s2     <= '1;
      r_stable <= '1;
      for (int i = 0; i < 10; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 10; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == 4'(DEBOUNCE_TICKS - 1)) begin
            r_stable[i] <= r_s2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  assign w_fire_db = ~{r_stable[9], r_stable[4]};

`ifdef MEGA99_JOY_AUTOFIRE_EN
  logic [7:0] r_af_cnt [2];
  logic [1:0] r_af_phase;

  // Phase idles high so the first autofire half-period starts with fire asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_af_cnt[0] <= '0;
      r_af_cnt[1] <= '0;
      r_af_phase  <= '1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (!(w_fire_db[n] && bus.autofire[n])) begin
          r_af_cnt[n]   <= '0;
          r_af_phase[n] <= 1'b1;
        end else if (w_tick) begin
          if (r_af_cnt[n] == 8'(AUTOFIRE_TICKS - 1)) begin
            r_af_cnt[n]   <= '0;
            r_af_phase[n] <= ~r_af_phase[n];
          end else begin
            r_af_cnt[n] <= r_af_cnt[n] + 8'd1;
          end
        end
      end
    end
  end

  assign w_fire = w_fire_db & (~bus.autofire | r_af_phase);
`else
  assign w_fire = w_fire_db;
`endif

  // Pin order {fire,right,left,down,up} -> mainboard order {fire,left,right,down,up}.
  assign w_joy1_next = {w_fire[0], ~r_stable[2], ~r_stable[3], ~r_stable[1], ~r_stable[0]};
  assign w_joy2_next = {w_fire[1], ~r_stable[7], ~r_stable[8], ~r_stable[6], ~r_stable[5]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.joy1        <= '0;
      bus.joy2        <= '0;
      bus.joy_changed <= 1'b0;
    end else begin
      bus.joy1        <= w_joy1_next;
      bus.joy2        <= w_joy2_next;
      bus.joy_changed <= (w_joy1_next != bus.joy1) || (w_joy2_next != bus.joy2);
    end
  end

endmodule

// File: tb/tb_pmod_joystick_conditioner.sv
// Directed bench for pmod_joystick_conditioner at PRESCALE=4, DEBOUNCE_TICKS=3, AUTOFIRE_TICKS=2.
module tb_pmod_joystick_conditioner;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   pulses;

  pmod_joystick_conditioner_if jif ();

  pmod_joystick_conditioner #(
    .PRESCALE       (4),
    .DEBOUNCE_TICKS (3),
    .AUTOFIRE_TICKS (2)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (jif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pulses = 0;
  always @(negedge clk) if (jif.joy_changed === 1'b1) pulses = pulses + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int lat;
    int base;
    int last;
    n_cmp = 0;
    n_bad = 0;
    rst          = 1'b1;
    jif.ja_pin   = 5'b11111;
    jif.jb_pin   = 5'b11111;
    jif.autofire = 2'b00;

    // 1: reset state, during and after reset
    wait_clk(3);
    chk("t1_rst_joy1", int'(jif.joy1), 0);
    chk("t1_rst_joy2", int'(jif.joy2), 0);
    chk("t1_rst_chg", int'(jif.joy_changed), 0);
    rst = 1'b0;
    base = pulses;
    wait_clk(20);
    chk("t1_idle_joy1", int'(jif.joy1), 0);
    chk("t1_idle_joy2", int'(jif.joy2), 0);
    chk("t1_idle_pulses", pulses - base, 0);

    // 2: up on JA, latency window and a single change pulse
    base = pulses;
    jif.ja_pin[0] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (jif.joy1 != 5'b00000) begin lat = i; break; end
    end
    chk("t2_latency_in_9_15", int'(lat >= 9 && lat <= 15), 1);
    chk("t2_joy1", int'(jif.joy1), 5'b00001);
    wait_clk(20);
    chk("t2_pulses", pulses - base, 1);
    chk("t2_joy2", int'(jif.joy2), 0);
    jif.ja_pin = 5'b11111;
    wait_clk(20);
    chk("t2_release", int'(jif.joy1), 0);

    // 3: 5-clk glitch on JB fire is rejected
    base = pulses;
    jif.jb_pin[4] = 1'b0;
    wait_clk(5);
    jif.jb_pin[4] = 1'b1;
    wait_clk(20);
    chk("t3_joy2", int'(jif.joy2), 0);
    chk("t3_pulses", pulses - base, 0);

    // 4: simultaneous left on JA and right on JB
    base = pulses;
    jif.ja_pin[2] = 1'b0;
    jif.jb_pin[3] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (jif.joy1 != 5'b00000 || jif.joy2 != 5'b00000) break;
    end
    chk("t4_joy1", int'(jif.joy1), 5'b01000);
    chk("t4_joy2", int'(jif.joy2), 5'b00100);
    wait_clk(10);
    chk("t4_pulses", pulses - base, 1);
    jif.ja_pin = 5'b11111;
    jif.jb_pin = 5'b11111;
    wait_clk(20);
    chk("t4_release", int'(jif.joy1 | jif.joy2), 0);

    // 5: reset mid-debounce discards the pending count
    jif.ja_pin[1] = 1'b0;
    wait_clk(6);
    chk("t5_pre_joy1", int'(jif.joy1), 0);
    rst = 1'b1;
    wait_clk(1);
    chk("t5_rst_joy1", int'(jif.joy1), 0);
    chk("t5_rst_chg", int'(jif.joy_changed), 0);
    wait_clk(2);
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (jif.joy1 != 5'b00000) begin lat = i; break; end
    end
    chk("t5_latency_in_9_15", int'(lat >= 9 && lat <= 15), 1);
    chk("t5_joy1", int'(jif.joy1), 5'b00010);
    jif.ja_pin = 5'b11111;
    wait_clk(20);
    chk("t5_release", int'(jif.joy1), 0);

`ifdef MEGA99_JOY_AUTOFIRE_EN
    // 6: autofire on joystick 1 fire, 8-clk half-period, then steady when disabled
    jif.autofire = 2'b01;
    jif.ja_pin[4] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (jif.joy1[0] == 1'b1) begin lat = i; break; end
    end
    chk("t6_fire_on", int'(lat != 0), 1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (jif.joy1[0] == 1'b0) begin lat = i; break; end
    end
    chk("t6_first_toggle", int'(lat != 0), 1);
    for (int k = 0; k < 2; k++) begin
      last = int'(jif.joy1[0]);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (int'(jif.joy1[0]) != last) begin lat = i; break; end
      end
      chk("t6_half_period", lat, 8);
    end
    jif.autofire = 2'b00;
    wait_clk(2);
    chk("t6_steady_fire", int'(jif.joy1[0]), 1);
    base = pulses;
    wait_clk(20);
    chk("t6_steady_pulses", pulses - base, 0);
    jif.ja_pin = 5'b11111;
    wait_clk(20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
